// File: rtl/dram_port_arbiter_if.sv
// Bundle of both requester ports plus the RAM-side command/data signals
// for the data-RAM port arbiter.
interface dram_port_arbiter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADD_WIDTH  = 5
);
   logic                  req_a;
   logic                  we_a;
   logic [ADD_WIDTH-1:0]  add_a;
   logic [DATA_WIDTH-1:0] din_a;
   logic                  gnt_a;
   logic                  rvalid_a;

   logic                  req_b;
   logic                  we_b;
   logic [ADD_WIDTH-1:0]  add_b;
   logic [DATA_WIDTH-1:0] din_b;
   logic                  gnt_b;
   logic                  rvalid_b;

   logic [DATA_WIDTH-1:0] rdata;
   logic                  mem_we;
   logic [ADD_WIDTH-1:0]  mem_add;
   logic [DATA_WIDTH-1:0] mem_din;
   logic [DATA_WIDTH-1:0] mem_dout;
   logic                  busy;

   modport slave (
      input  req_a, we_a, add_a, din_a,
      input  req_b, we_b, add_b, din_b,
      input  mem_dout,
      output gnt_a, rvalid_a, gnt_b, rvalid_b,
      output rdata, mem_we, mem_add, mem_din, busy
   );

   modport master (
      output req_a, we_a, add_a, din_a,
      output req_b, we_b, add_b, din_b,
      output mem_dout,
      input  gnt_a, rvalid_a, gnt_b, rvalid_b,
      input  rdata, mem_we, mem_add, mem_din, busy
   );
endinterface

// File: rtl/dram_port_arbiter.sv
// Shares the single-port data RAM between the CPU (port A, priority) and the
// SPI slave (port B), with a wait counter that forces B through after MAX_WAIT losses.
//
// state | meaning
// IDLE  | no access on the RAM port
// ACC_A | A's registered command is on mem_*, gnt_a high
// ACC_B | B's registered command is on mem_*, gnt_b high
module dram_port_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADD_WIDTH  = 5,
   parameter int MAX_WAIT   = 4
) (
   input logic             clk,
   input logic             reset,
   dram_port_arbiter_if.slave bus
);
   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, ACC_A, ACC_B} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
   logic                  rvalid_a_q, rvalid_a_d;
   logic                  rvalid_b_q, rvalid_b_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADD_WIDTH-1:0]  mem_add_q, mem_add_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;

   logic elig_a, elig_b, pick_a, pick_b;

   always_comb begin
      // A request still high during its own grant cycle is the one being served.
      elig_a = bus.req_a & (state_q != ACC_A);
      elig_b = bus.req_b & (state_q != ACC_B);
      pick_b = elig_b & (~elig_a | (wait_cnt_q == CW'(MAX_WAIT)));
      pick_a = elig_a & ~pick_b;

      state_d    = IDLE;
      wait_cnt_d = wait_cnt_q;
      mem_we_d   = 1'b0;
      mem_add_d  = mem_add_q;
      mem_din_d  = mem_din_q;

      if (pick_b) begin
         state_d    = ACC_B;
         mem_we_d   = bus.we_b;
         mem_add_d  = bus.add_b;
         mem_din_d  = bus.din_b;
         wait_cnt_d = '0;
      end else if (pick_a) begin
         state_d   = ACC_A;
         mem_we_d  = bus.we_a;
         mem_add_d = bus.add_a;
         mem_din_d = bus.din_a;
         if (elig_b && (wait_cnt_q != CW'(MAX_WAIT)))
            wait_cnt_d = wait_cnt_q + CW'(1);
      end

      // The RAM returns data one cycle after the read command sits on its port.
      rvalid_a_d = (state_q == ACC_A) & ~mem_we_q;
      rvalid_b_d = (state_q == ACC_B) & ~mem_we_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_add_q  <= '0;
         mem_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rvalid_a_q <= rvalid_a_d;
         rvalid_b_q <= rvalid_b_d;
         mem_we_q   <= mem_we_d;
         mem_add_q  <= mem_add_d;
         mem_din_q  <= mem_din_d;
      end
   end

   assign bus.gnt_a    = (state_q == ACC_A);
   assign bus.gnt_b    = (state_q == ACC_B);
   assign bus.busy     = (state_q != IDLE);
   assign bus.rvalid_a = rvalid_a_q;
   assign bus.rvalid_b = rvalid_b_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_add  = mem_add_q;
   assign bus.mem_din  = mem_din_q;
   assign bus.rdata    = bus.mem_dout;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed vector bench for dram_port_arbiter with a behavioural 32x16 sync RAM.
module tb_dram_port_arbiter;
   logic clk;
   logic reset;

   dram_port_arbiter_if #(.DATA_WIDTH(16), .ADD_WIDTH(5)) bus ();

   dram_port_arbiter #(.DATA_WIDTH(16), .ADD_WIDTH(5), .MAX_WAIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] ram [32];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_add] <= bus.mem_din;
      bus.mem_dout <= ram[bus.mem_add];
   end

   typedef struct {
      bit        rst;
      bit        ra;
      bit        wa;
      bit [4:0]  aa;
      bit [15:0] da;
      bit        rb;
      bit        wb;
      bit [4:0]  ab;
      bit [15:0] db;
      bit        ga;
      bit        gb;
      bit        va;
      bit        vb;
      bit        mwe;
      bit [4:0]  madd;
      bit [15:0] mdin;
      bit        busy;
      bit [2:0]  wc;
      bit [15:0] rdat;
   } vec_t;

   localparam int NV = 34;
   vec_t vecs [NV];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
   endtask

   task automatic drive(input vec_t v);
      reset     = v.rst;
      bus.req_a = v.ra;  bus.we_a = v.wa;  bus.add_a = v.aa;  bus.din_a = v.da;
      bus.req_b = v.rb;  bus.we_b = v.wb;  bus.add_b = v.ab;  bus.din_b = v.db;
   endtask

   initial begin
      int ta, tb, seen_vb, seen_va;
      logic [15:0] got_rd;

      for (int i = 0; i < 32; i++) ram[i] = '0;

      //         rst ra wa aa  da       rb wb ab  db       ga gb va vb mwe madd mdin     busy wc rdat
      vecs[0]  = '{1, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 0,  16'h0,    0, 0, 16'h0};
      vecs[1]  = '{1, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 0,  16'h0,    0, 0, 16'h0};
      vecs[2]  = '{0, 1, 1, 5,  16'hBEEF, 0, 0, 0,  16'h0,    1, 0, 0, 0, 1, 5,  16'hBEEF, 1, 0, 16'h0};
      vecs[3]  = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 5,  16'hBEEF, 0, 0, 16'h0};
      vecs[4]  = '{0, 1, 0, 5,  16'h0,    0, 0, 0,  16'h0,    1, 0, 0, 0, 0, 5,  16'h0,    1, 0, 16'h0};
      vecs[5]  = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 1, 0, 0, 5,  16'h0,    0, 0, 16'hBEEF};
      vecs[6]  = '{0, 1, 1, 1,  16'h1111, 1, 1, 3,  16'h1234, 1, 0, 0, 0, 1, 1,  16'h1111, 1, 1, 16'h0};
      vecs[7]  = '{0, 0, 0, 0,  16'h0,    1, 1, 3,  16'h1234, 0, 1, 0, 0, 1, 3,  16'h1234, 1, 0, 16'h0};
      vecs[8]  = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 3,  16'h1234, 0, 0, 16'h0};
      vecs[9]  = '{0, 1, 1, 7,  16'h7777, 1, 0, 3,  16'h0,    1, 0, 0, 0, 1, 7,  16'h7777, 1, 1, 16'h0};
      vecs[10] = '{0, 0, 0, 0,  16'h0,    1, 0, 3,  16'h0,    0, 1, 0, 0, 0, 3,  16'h0,    1, 0, 16'h0};
      vecs[11] = '{0, 1, 1, 8,  16'h8888, 0, 0, 0,  16'h0,    1, 0, 0, 1, 1, 8,  16'h8888, 1, 0, 16'h1234};
      vecs[12] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 8,  16'h8888, 0, 0, 16'h0};
      // B repeatedly loses to A and withdraws, driving the wait counter up to its limit
      vecs[13] = '{0, 1, 1, 9,  16'h0009, 1, 1, 10, 16'h00AA, 1, 0, 0, 0, 1, 9,  16'h0009, 1, 1, 16'h0};
      vecs[14] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 9,  16'h0009, 0, 1, 16'h0};
      vecs[15] = '{0, 1, 1, 9,  16'h0009, 1, 1, 10, 16'h00AA, 1, 0, 0, 0, 1, 9,  16'h0009, 1, 2, 16'h0};
      vecs[16] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 9,  16'h0009, 0, 2, 16'h0};
      vecs[17] = '{0, 1, 1, 9,  16'h0009, 1, 1, 10, 16'h00AA, 1, 0, 0, 0, 1, 9,  16'h0009, 1, 3, 16'h0};
      vecs[18] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 9,  16'h0009, 0, 3, 16'h0};
      vecs[19] = '{0, 1, 1, 9,  16'h0009, 1, 1, 10, 16'h00AA, 1, 0, 0, 0, 1, 9,  16'h0009, 1, 4, 16'h0};
      vecs[20] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 9,  16'h0009, 0, 4, 16'h0};
      vecs[21] = '{0, 1, 1, 9,  16'h0009, 1, 1, 10, 16'h00AA, 0, 1, 0, 0, 1, 10, 16'h00AA, 1, 0, 16'h0};
      vecs[22] = '{0, 1, 1, 9,  16'h0009, 0, 0, 0,  16'h0,    1, 0, 0, 0, 1, 9,  16'h0009, 1, 0, 16'h0};
      vecs[23] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 9,  16'h0009, 0, 0, 16'h0};
      vecs[24] = '{0, 1, 0, 5,  16'h0,    1, 0, 3,  16'h0,    1, 0, 0, 0, 0, 5,  16'h0,    1, 1, 16'h0};
      vecs[25] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 1, 0, 0, 5,  16'h0,    0, 1, 16'hBEEF};
      vecs[26] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 5,  16'h0,    0, 1, 16'h0};
      // reset lands in the grant cycle of an A read; its rvalid must never appear
      vecs[27] = '{0, 1, 0, 5,  16'h0,    0, 0, 0,  16'h0,    1, 0, 0, 0, 0, 5,  16'h0,    1, 1, 16'h0};
      vecs[28] = '{1, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 0,  16'h0,    0, 0, 16'h0};
      vecs[29] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 0,  16'h0,    0, 0, 16'h0};
      vecs[30] = '{0, 1, 0, 5,  16'h0,    1, 0, 3,  16'h0,    1, 0, 0, 0, 0, 5,  16'h0,    1, 1, 16'h0};
      vecs[31] = '{0, 0, 0, 0,  16'h0,    1, 0, 3,  16'h0,    0, 1, 1, 0, 0, 3,  16'h0,    1, 0, 16'hBEEF};
      vecs[32] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 1, 0, 3,  16'h0,    0, 0, 16'h1234};
      vecs[33] = '{0, 0, 0, 0,  16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 3,  16'h0,    0, 0, 16'h0};

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         chk("gnt_a",    i, 32'(bus.gnt_a),    32'(vecs[i].ga));
         chk("gnt_b",    i, 32'(bus.gnt_b),    32'(vecs[i].gb));
         chk("rvalid_a", i, 32'(bus.rvalid_a), 32'(vecs[i].va));
         chk("rvalid_b", i, 32'(bus.rvalid_b), 32'(vecs[i].vb));
         chk("mem_we",   i, 32'(bus.mem_we),   32'(vecs[i].mwe));
         chk("mem_add",  i, 32'(bus.mem_add),  32'(vecs[i].madd));
         chk("mem_din",  i, 32'(bus.mem_din),  32'(vecs[i].mdin));
         chk("busy",     i, 32'(bus.busy),     32'(vecs[i].busy));
         chk("wait_cnt", i, 32'(dut.wait_cnt_q), 32'(vecs[i].wc));
         if (vecs[i].va || vecs[i].vb)
            chk("rdata", i, 32'(bus.rdata), 32'(vecs[i].rdat));
      end

      // Both ports hold write requests until granted: A must go first, B right after.
      bus.req_a = 1; bus.we_a = 1; bus.add_a = 5'd2; bus.din_a = 16'h2222;
      bus.req_b = 1; bus.we_b = 1; bus.add_b = 5'd4; bus.din_b = 16'h4444;
      ta = -1; tb = -1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         #1;
         if (bus.gnt_a && ta < 0) begin ta = c; bus.req_a = 0; end
         if (bus.gnt_b && tb < 0) begin tb = c; bus.req_b = 0; end
      end
      chk("seq_gnt_a_slot", 100, ta, 1);
      chk("seq_gnt_b_slot", 100, tb, 2);

      // B reads back what it wrote; bounded wait for rvalid_b, A must stay silent.
      bus.req_b = 1; bus.we_b = 0; bus.add_b = 5'd4; bus.din_b = 16'h0;
      seen_vb = 0; seen_va = 0; got_rd = '0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #1;
         if (bus.gnt_b) bus.req_b = 0;
         if (bus.rvalid_a) seen_va = 1;
         if (bus.rvalid_b && seen_vb == 0) begin seen_vb = c; got_rd = bus.rdata; end
      end
      chk("seq_rvalid_b_cycle", 101, seen_vb, 2);
      chk("seq_rdata_b",        101, 32'(got_rd), 32'h4444);
      chk("seq_no_rvalid_a",    101, seen_va, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
